// File: rtl/instruction_l1.sv
// Direct-mapped, one-word-per-line L1 instruction cache with registered hit/data outputs.
// Optional read hit/miss counters are compiled in with INSTRUCTION_L1_STATS_EN.
module instruction_l1 #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [ADDR_W-1:0] WriteAddress_Full,
    input  logic [DATA_W-1:0] WriteValue,
    input  logic [ADDR_W-1:0] ReadAddress_Full,
    output logic [DATA_W-1:0] ReadValue,
    output logic              WriteHit,
    output logic              ReadHit
`ifdef INSTRUCTION_L1_STATS_EN
    ,
    output logic [15:0]       ReadHitCount,
    output logic [15:0]       ReadMissCount
`endif
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;
    localparam int unsigned TagW  = ADDR_W - INDEX_BITS;

    logic [Lines-1:0]  valid_q, valid_d;
    logic [TagW-1:0]   tag_q  [Lines];
    logic [DATA_W-1:0] data_q [Lines];

    logic [DATA_W-1:0] read_value_q, read_value_d;
    logic              write_hit_q, write_hit_d;
    logic              read_hit_q, read_hit_d;

    logic [INDEX_BITS-1:0] w_idx, r_idx;
    logic [TagW-1:0]       w_tag, r_tag;
    logic                  w_hit, r_hit;

    assign w_idx = WriteAddress_Full[INDEX_BITS-1:0];
    assign w_tag = WriteAddress_Full[ADDR_W-1:INDEX_BITS];
    assign r_idx = ReadAddress_Full[INDEX_BITS-1:0];
    assign r_tag = ReadAddress_Full[ADDR_W-1:INDEX_BITS];

    // Lookups use pre-edge contents, so a fill is never seen by the same edge's lookup.
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    always_comb begin
        valid_d      = valid_q;
        read_value_d = read_value_q;
        write_hit_d  = 1'b0;
        read_hit_d   = 1'b0;
        if (mode) begin
            write_hit_d    = w_hit;
            valid_d[w_idx] = 1'b1;
        end else begin
            read_hit_d   = r_hit;
            read_value_d = r_hit ? data_q[r_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            read_value_q <= '0;
            write_hit_q  <= 1'b0;
            read_hit_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            read_value_q <= read_value_d;
            write_hit_q  <= write_hit_d;
            read_hit_q   <= read_hit_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone make stale lines invisible.
    always_ff @(posedge clk) begin
        if (mode && !reset) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= WriteValue;
        end
    end

    assign ReadValue = read_value_q;
    assign WriteHit  = write_hit_q;
    assign ReadHit   = read_hit_q;

`ifdef INSTRUCTION_L1_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (!mode) begin
            if (r_hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
            if (!r_hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign ReadHitCount  = hit_cnt_q;
    assign ReadMissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_l1.sv
// Self-checking bench for instruction_l1: directed cases plus random traffic checked
// against a line-residency model; also checks the counters when INSTRUCTION_L1_STATS_EN is set.
module tb_instruction_l1;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [15:0] WriteAddress_Full;
    logic [15:0] WriteValue;
    logic [15:0] ReadAddress_Full;
    logic [15:0] ReadValue;
    logic        WriteHit;
    logic        ReadHit;
`ifdef INSTRUCTION_L1_STATS_EN
    logic [15:0] ReadHitCount;
    logic [15:0] ReadMissCount;
`endif

    instruction_l1 dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .WriteAddress_Full(WriteAddress_Full),
        .WriteValue       (WriteValue),
        .ReadAddress_Full (ReadAddress_Full),
        .ReadValue        (ReadValue),
        .WriteHit         (WriteHit),
        .ReadHit          (ReadHit)
`ifdef INSTRUCTION_L1_STATS_EN
        ,
        .ReadHitCount     (ReadHitCount),
        .ReadMissCount    (ReadMissCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_fail;

    // Model: each of the 8 lines remembers the full address it holds and that address's word.
    bit          m_valid [8];
    logic [15:0] m_addr  [8];
    logic [15:0] m_data  [8];
    logic [15:0] exp_rv;
    logic        exp_rh;
    logic        exp_wh;
    int          exp_hits;
    int          exp_misses;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        exp_rv     = 16'h0;
        exp_rh     = 1'b0;
        exp_wh     = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Applies one request for one clock, then advances the model; outputs settle #1 after the edge.
    task automatic do_cycle(input bit m, input logic [15:0] wa, input logic [15:0] wv,
                            input logic [15:0] ra);
        int idx;
        mode              = m;
        WriteAddress_Full = wa;
        WriteValue        = wv;
        ReadAddress_Full  = ra;
        @(posedge clk);
        #1;
        if (m) begin
            idx    = wa % 8;
            exp_wh = m_valid[idx] && (m_addr[idx] == wa);
            exp_rh = 1'b0;
            m_valid[idx] = 1;
            m_addr[idx]  = wa;
            m_data[idx]  = wv;
        end else begin
            idx    = ra % 8;
            exp_wh = 1'b0;
            exp_rh = m_valid[idx] && (m_addr[idx] == ra);
            exp_rv = exp_rh ? m_data[idx] : 16'h0;
            if (exp_rh) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : 65535;
            else        exp_misses = (exp_misses < 65535) ? exp_misses + 1 : 65535;
        end
    endtask

    task automatic test_reset();
        mode = 1'b0; WriteAddress_Full = '0; WriteValue = '0; ReadAddress_Full = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #2;
        n_vec++;
        if (ReadValue !== 16'h0 || ReadHit !== 1'b0 || WriteHit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%h rh=%b wh=%b, want 0/0/0",
                     ReadValue, ReadHit, WriteHit);
        end
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        do_cycle(1'b0, 16'h0, 16'h0, 16'h0);
        n_vec++;
        if (ReadHit !== 1'b0 || ReadValue !== 16'h0 || WriteHit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read0: got rh=%b rv=%h wh=%b, want 0/0000/0",
                     ReadHit, ReadValue, WriteHit);
        end
    endtask

    task automatic test_fill_and_evict();
        do_cycle(1'b1, 16'd0, 16'd23, 16'd5);
        n_vec++;
        if (WriteHit !== 1'b0 || ReadHit !== 1'b0) begin
            n_fail++; $display("FAIL write0: got wh=%b rh=%b, want 0/0", WriteHit, ReadHit);
        end
        do_cycle(1'b0, 16'd3, 16'd0, 16'd0);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'd23) begin
            n_fail++; $display("FAIL read0: got rh=%b rv=%0d, want 1/23", ReadHit, ReadValue);
        end
        do_cycle(1'b1, 16'd1, 16'd42, 16'd0);
        n_vec++;
        if (WriteHit !== 1'b0) begin
            n_fail++; $display("FAIL write1: got wh=%b, want 0", WriteHit);
        end
        do_cycle(1'b0, 16'd0, 16'd0, 16'd1);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'd42) begin
            n_fail++; $display("FAIL read1: got rh=%b rv=%0d, want 1/42", ReadHit, ReadValue);
        end
        do_cycle(1'b0, 16'd0, 16'd0, 16'd0);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'd23) begin
            n_fail++; $display("FAIL reread0: got rh=%b rv=%0d, want 1/23", ReadHit, ReadValue);
        end
        do_cycle(1'b1, 16'd8, 16'd62, 16'd0);
        n_vec++;
        if (WriteHit !== 1'b0 || ReadHit !== 1'b0 || ReadValue !== 16'd23) begin
            n_fail++;
            $display("FAIL write8_hold: got wh=%b rh=%b rv=%0d, want 0/0/23",
                     WriteHit, ReadHit, ReadValue);
        end
        do_cycle(1'b0, 16'd0, 16'd0, 16'd8);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'd62) begin
            n_fail++; $display("FAIL read8: got rh=%b rv=%0d, want 1/62", ReadHit, ReadValue);
        end
        do_cycle(1'b0, 16'd8, 16'd0, 16'd0);
        n_vec++;
        if (ReadHit !== 1'b0 || ReadValue !== 16'd0) begin
            n_fail++;
            $display("FAIL read0_evicted: got rh=%b rv=%0d, want 0/0", ReadHit, ReadValue);
        end
        do_cycle(1'b1, 16'd1, 16'd99, 16'd0);
        n_vec++;
        if (WriteHit !== 1'b1) begin
            n_fail++; $display("FAIL rewrite1: got wh=%b, want 1", WriteHit);
        end
        do_cycle(1'b0, 16'd0, 16'd0, 16'd1);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'd99) begin
            n_fail++; $display("FAIL read1_new: got rh=%b rv=%0d, want 1/99", ReadHit, ReadValue);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [4];
        logic [15:0] addrs [4];
        addrs[0] = 16'h0005; addrs[1] = 16'h0005; addrs[2] = 16'h000D; addrs[3] = 16'h000D;
        want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd0; want[3] = 2'd1;
        do_cycle(1'b1, 16'h1235, 16'h0001, 16'h0); // different tag primes index 5
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, addrs[i], 16'h0A00 + 16'(i), 16'h0);
            n_vec++;
            if (WriteHit !== want[i][0]) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got wh=%b, want %b", i, WriteHit, want[i][0]);
            end
        end
        do_cycle(1'b0, 16'h0, 16'h0, 16'h000D);
        n_vec++;
        if (ReadHit !== 1'b1 || ReadValue !== 16'h0A03) begin
            n_fail++;
            $display("FAIL b2b_read: got rh=%b rv=%h, want 1/0a03", ReadHit, ReadValue);
        end
    endtask

    task automatic test_async_reset();
        do_cycle(1'b1, 16'd0, 16'd23, 16'd0);
        do_cycle(1'b1, 16'd1, 16'd42, 16'd0);
        do_cycle(1'b0, 16'd0, 16'd0, 16'd1);
        reset = 1'b1;
        model_reset();
        #2;
        n_vec++;
        if (ReadValue !== 16'h0 || ReadHit !== 1'b0 || WriteHit !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rv=%h rh=%b wh=%b, want 0/0/0",
                     ReadValue, ReadHit, WriteHit);
        end
`ifdef INSTRUCTION_L1_STATS_EN
        n_vec++;
        if (ReadHitCount !== 16'd0 || ReadMissCount !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got hits=%0d misses=%0d, want 0/0",
                     ReadHitCount, ReadMissCount);
        end
`endif
        // A write presented during reset must not be taken.
        mode = 1'b1; WriteAddress_Full = 16'd0; WriteValue = 16'd77;
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        do_cycle(1'b0, 16'd0, 16'd0, 16'd0);
        n_vec++;
        if (ReadHit !== 1'b0 || ReadValue !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_read0: got rh=%b rv=%0d, want 0/0", ReadHit, ReadValue);
        end
        do_cycle(1'b0, 16'd0, 16'd0, 16'd1);
        n_vec++;
        if (ReadHit !== 1'b0 || ReadValue !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_read1: got rh=%b rv=%0d, want 0/0", ReadHit, ReadValue);
        end
`ifdef INSTRUCTION_L1_STATS_EN
        n_vec++;
        if (ReadHitCount !== 16'd0 || ReadMissCount !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_post_reset: got hits=%0d misses=%0d, want 0/2",
                     ReadHitCount, ReadMissCount);
        end
`endif
    endtask

    task automatic test_random();
        bit          m;
        logic [15:0] wa, ra, wv;
        for (int i = 0; i < 400; i++) begin
            m  = ($urandom_range(0, 99) < 45);
            wa = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23));
            ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23));
            wv = 16'($urandom);
            do_cycle(m, wa, wv, ra);
            n_vec++;
            if (ReadValue !== exp_rv || ReadHit !== exp_rh || WriteHit !== exp_wh) begin
                n_fail++;
                $display("FAIL random%0d: mode=%b wa=%h ra=%h got rv=%h rh=%b wh=%b, want rv=%h rh=%b wh=%b",
                         i, m, wa, ra, ReadValue, ReadHit, WriteHit, exp_rv, exp_rh, exp_wh);
            end
`ifdef INSTRUCTION_L1_STATS_EN
            n_vec++;
            if (ReadHitCount !== 16'(exp_hits) || ReadMissCount !== 16'(exp_misses)) begin
                n_fail++;
                $display("FAIL random_stats%0d: got hits=%0d misses=%0d, want %0d/%0d",
                         i, ReadHitCount, ReadMissCount, exp_hits, exp_misses);
            end
`endif
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_fill_and_evict();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
